sfq_pulse_tx: RTL and testbench

SFQ_PULSE_TX -- requirements
Module: sfq_pulse_tx

---
 rtl/sfq_tx_pkg.sv | 24 ++
 rtl/sfq_bit_fifo.sv | 75 +++++++
 rtl/sfq_pulse_tx.sv | 147 ++++++++++++++
 tb/tb_sfq_pulse_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfq_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sfq_tx_pkg
//  Purpose  : Shared types and defaults for the SFQ pulse transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package sfq_tx_pkg;

  // Slot sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2
  } tx_state_t;

  localparam int C_DEF_DEPTH     = 4;
  localparam int C_DEF_SETUP_CYC = 1;
  localparam int C_DEF_HOLD_CYC  = 1;

  // Slot counter width; covers the 1..15 range of both timing parameters
  localparam int C_CNT_W = 4;

endpackage : sfq_tx_pkg
`default_nettype wire

// File: rtl/sfq_bit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sfq_bit_fifo
//  Purpose  : 1-bit wide synchronous FIFO with full/empty/level outputs.
//             Output data is only valid for entries written on an earlier
//             edge, so there is no same-cycle bypass.
//  Revision : 1.0  initial release
// ============================================================================
module sfq_bit_fifo
  import sfq_tx_pkg::*;
#(
  parameter int DEPTH = C_DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_data,
  input  logic                     i_pop,
  output logic                     o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [LW-1:0] C_LVL_ONE = LW'(1);
  localparam logic [LW-1:0] C_LVL_MAX = LW'(DEPTH);

  logic            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            w_push;
  logic            w_pop;

  // A push while full is refused even when a pop happens on the same edge
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_level == C_LVL_MAX);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + C_LVL_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - C_LVL_ONE;
      end
    end
  end

endmodule : sfq_bit_fifo
`default_nettype wire

// File: rtl/sfq_pulse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sfq_pulse_tx
//  Purpose  : Serialises queued bits into toggle-encoded SFQ data/clock pulse
//             pairs. Each slot optionally toggles a_tgl, waits SETUP_CYC+1
//             edges, toggles clk_tgl, then holds HOLD_CYC+1 edges before the
//             next slot may start.
//  Revision : 1.0  initial release
// ============================================================================
module sfq_pulse_tx
  import sfq_tx_pkg::*;
#(
  parameter int DEPTH     = C_DEF_DEPTH,
  parameter int SETUP_CYC = C_DEF_SETUP_CYC,
  parameter int HOLD_CYC  = C_DEF_HOLD_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_data,
  output logic                     in_ready,
  output logic                     a_tgl,
  output logic                     clk_tgl,
  output logic                     exp_q,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic [C_CNT_W-1:0] C_SETUP_LD = C_CNT_W'(SETUP_CYC);
  localparam logic [C_CNT_W-1:0] C_HOLD_LD  = C_CNT_W'(HOLD_CYC);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_CNT_W-1:0]    w_cnt_nxt;
  logic                  r_bit;
  logic                  w_bit_nxt;
  logic                  r_a_tgl;
  logic                  r_clk_tgl;
  logic                  r_exp_q;
  logic                  w_pop;
  logic                  w_tog_a;
  logic                  w_tog_clk;
  logic                  w_push;
  logic                  w_fifo_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  assign w_push = in_valid && !w_fifo_full;

  sfq_bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (level)
  );

  // Slot sequencer: next state, counter reload, and which line toggles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_tog_a     = 1'b0;
    w_tog_clk   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_bit_nxt   = w_fifo_data;
          w_tog_a     = w_fifo_data;
          w_cnt_nxt   = C_SETUP_LD;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        // Clock pulse fires on the edge after the count has run down to 0
        if (r_cnt == '0) begin
          w_tog_clk   = 1'b1;
          w_cnt_nxt   = C_HOLD_LD;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      HOLD: begin
        w_cnt_nxt = r_cnt - C_CNT_ONE;
        if (r_cnt <= C_CNT_ONE) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any slot in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Toggle lines; exp_q follows the bit latched by the downstream DFF
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_tgl   <= 1'b0;
      r_clk_tgl <= 1'b0;
      r_exp_q   <= 1'b0;
    end else begin
      if (w_tog_a) begin
        r_a_tgl <= ~r_a_tgl;
      end
      if (w_tog_clk) begin
        r_clk_tgl <= ~r_clk_tgl;
        if (r_bit) begin
          r_exp_q <= ~r_exp_q;
        end
      end
    end
  end

  assign a_tgl    = r_a_tgl;
  assign clk_tgl  = r_clk_tgl;
  assign exp_q    = r_exp_q;
  assign in_ready = !w_fifo_full;
  assign busy     = (r_state != IDLE) || !w_fifo_empty;

endmodule : sfq_pulse_tx
`default_nettype wire

// File: tb/tb_sfq_pulse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfq_pulse_tx
//  Purpose  : Directed self-checking bench for sfq_pulse_tx (default timing
//             instance plus a SETUP_CYC=3 / HOLD_CYC=2 instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sfq_pulse_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_data;

  logic       in_ready, a_tgl, clk_tgl, exp_q, busy;
  logic [2:0] level;
  logic       in_ready2, a_tgl2, clk_tgl2, exp_q2, busy2;
  logic [2:0] level2;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // toggle monitors
  logic p_a, p_c, p_q, p_a2, p_c2;
  int   a_n, c_n, q_n, lvl_max, a2_n, c2_n;
  int   c_t  [16];
  int   a2_t [8];
  int   c2_t [8];

  always #5 clk = ~clk;

  sfq_pulse_tx dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a_tgl    (a_tgl),
    .clk_tgl  (clk_tgl),
    .exp_q    (exp_q),
    .busy     (busy),
    .level    (level)
  );

  sfq_pulse_tx #(
    .DEPTH     (4),
    .SETUP_CYC (3),
    .HOLD_CYC  (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready2),
    .a_tgl    (a_tgl2),
    .clk_tgl  (clk_tgl2),
    .exp_q    (exp_q2),
    .busy     (busy2),
    .level    (level2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    a_n = 0; c_n = 0; q_n = 0; lvl_max = 0; a2_n = 0; c2_n = 0;
    p_a = a_tgl; p_c = clk_tgl; p_q = exp_q; p_a2 = a_tgl2; p_c2 = clk_tgl2;
  endtask

  // advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (a_tgl != p_a) a_n++;
    if (clk_tgl != p_c) begin
      if (c_n < 16) c_t[c_n] = cyc;
      c_n++;
    end
    if (exp_q != p_q) q_n++;
    if (a_tgl2 != p_a2) begin
      if (a2_n < 8) a2_t[a2_n] = cyc;
      a2_n++;
    end
    if (clk_tgl2 != p_c2) begin
      if (c2_n < 8) c2_t[c2_n] = cyc;
      c2_n++;
    end
    if (int'(level) > lvl_max) lvl_max = int'(level);
    p_a = a_tgl; p_c = clk_tgl; p_q = exp_q; p_a2 = a_tgl2; p_c2 = clk_tgl2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clr_mon();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seq;
    seq = 5'b11011;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_a_tgl",   a_tgl,    0);
    chk("rst_clk_tgl", clk_tgl,  0);
    chk("rst_exp_q",   exp_q,    0);
    chk("rst_ready",   in_ready, 1);
    chk("rst_busy",    busy,     0);
    chk("rst_level",   level,    0);
    rst = 1'b0;
    clr_mon();

    // single '1' slot with default timing
    in_valid = 1'b1; in_data = 1'b1;
    tick();                                   // e0 push
    in_valid = 1'b0;
    chk("s1_e0_level", level, 1);
    chk("s1_e0_a",     a_tgl, 0);
    tick();                                   // e1 pop
    chk("s1_e1_a",     a_tgl, 1);
    chk("s1_e1_level", level, 0);
    tick();                                   // e2
    chk("s1_e2_clk",   clk_tgl, 0);
    tick();                                   // e3 clock pulse
    chk("s1_e3_clk",   clk_tgl, 1);
    chk("s1_e3_q",     exp_q,   1);
    chk("s1_e3_busy",  busy,    1);
    tick();
    tick();                                   // e5
    chk("s1_e5_busy",  busy,    0);

    // single '0' slot: clock only
    in_valid = 1'b1; in_data = 1'b0;
    tick();                                   // e0
    in_valid = 1'b0;
    tick();                                   // e1 pop
    chk("s0_e1_a",   a_tgl,   1);
    tick();                                   // e2
    chk("s0_e2_clk", clk_tgl, 1);
    tick();                                   // e3
    chk("s0_e3_clk", clk_tgl, 0);
    chk("s0_e3_q",   exp_q,   1);
    chk("s0_e3_a",   a_tgl,   1);
    tick();
    tick();

    // back-to-back 1,1,0,1,1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = seq[i];
      tick();
      if (i == 3) chk("b2b_ready_e3", in_ready, 1);
    end
    in_valid = 1'b0;
    chk("b2b_ready_full", in_ready, 0);
    chk("b2b_level_full", level,    4);
    repeat (20) tick();
    chk("b2b_a_cnt",   a_n,     4);
    chk("b2b_clk_cnt", c_n,     5);
    chk("b2b_q_cnt",   q_n,     4);
    chk("b2b_lvl_max", lvl_max, 4);
    for (int i = 1; i < 5; i++) chk("b2b_slot_period", c_t[i] - c_t[i-1], 4);
    chk("b2b_busy_end", busy, 0);

    // full FIFO: push refused while a pop happens
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 1'b1;
      tick();
    end
    chk("full_level_pre", level, 4);
    in_valid = 1'b1; in_data = 1'b0;
    tick();                                   // e5: pop, refused push
    in_valid = 1'b0;
    chk("full_level_pop", level,    3);
    chk("full_ready",     in_ready, 1);
    repeat (20) tick();
    chk("full_clk_cnt", c_n, 5);
    chk("full_a_cnt",   a_n, 5);

    // reset during SETUP
    do_reset();
    in_valid = 1'b1; in_data = 1'b1;
    tick();                                   // e0
    in_valid = 1'b0;
    tick();                                   // e1 a toggles
    chk("abort_a_pre", a_tgl, 1);
    rst = 1'b1;
    tick();
    chk("abort_a",     a_tgl,   0);
    chk("abort_clk",   clk_tgl, 0);
    chk("abort_level", level,   0);
    rst = 1'b0;
    clr_mon();
    repeat (8) tick();
    chk("abort_a_cnt",   a_n,  0);
    chk("abort_clk_cnt", c_n,  0);
    chk("abort_busy",    busy, 0);

    // SETUP_CYC=3, HOLD_CYC=2 instance
    do_reset();
    in_valid = 1'b1; in_data = 1'b1;
    tick();                                   // e0
    tick();                                   // e1
    in_valid = 1'b0;
    repeat (20) tick();
    chk("t2_a_cnt",   a2_n, 2);
    chk("t2_clk_cnt", c2_n, 2);
    chk("t2_a_to_clk",   c2_t[0] - a2_t[0], 4);
    chk("t2_clk_to_a",   a2_t[1] - c2_t[0], 3);
    chk("t2_period_a",   a2_t[1] - a2_t[0], 7);
    chk("t2_period_clk", c2_t[1] - c2_t[0], 7);
    chk("t2_q",       exp_q2, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_sfq_pulse_tx
`default_nettype wire
